// File: rtl/writeback_queue_if.sv
// Writeback queue bus: upstream request handshake, register-file write port,
// commit notification and occupancy status.
interface writeback_queue_if #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned RADDR_W = 4,
    parameter int unsigned DEPTH   = 4
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned NREG  = 2 ** RADDR_W;

    logic               in_valid;
    logic               in_ready;
    logic               in_wen;
    logic [RADDR_W-1:0] in_addr;
    logic [DATA_W-1:0]  in_data;
    logic               flush;
    logic               w_on;
    logic [RADDR_W-1:0] waddr;
    logic [DATA_W-1:0]  data_out;
    logic               rf_ready;
    logic               endwrite;
    logic [RADDR_W-1:0] endreg;
    logic [NREG-1:0]    pend_mask;
    logic [CNT_W-1:0]   count;

    // Upstream pipeline plus register file side.
    modport master (
        output in_valid, in_wen, in_addr, in_data, flush, rf_ready,
        input  in_ready, w_on, waddr, data_out, endwrite, endreg, pend_mask, count
    );

    // The queue itself.
    modport slave (
        input  in_valid, in_wen, in_addr, in_data, flush, rf_ready,
        output in_ready, w_on, waddr, data_out, endwrite, endreg, pend_mask, count
    );
endinterface

// File: rtl/writeback_queue.sv
// Writeback queue: buffers register-file writes in FIFO order, drops writes that
// do not update the register file, reports each commit, and exposes a mask of
// registers with writes still pending (for hazard detection upstream).
module writeback_queue #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned RADDR_W = 4,
    parameter int unsigned DEPTH   = 4,
    parameter bit          R0_ZERO = 1'b1
) (
    input logic              clk,
    input logic              rst_n,
    writeback_queue_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned NREG  = 2 ** RADDR_W;

    // Entry storage is never reset; validity comes from head/count alone.
    logic [RADDR_W-1:0] mem_addr_q [DEPTH];
    logic [DATA_W-1:0]  mem_data_q [DEPTH];

    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [RADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0]  data_out_q, data_out_d;
    logic               endwrite_q, endwrite_d;
    logic [RADDR_W-1:0] endreg_q, endreg_d;

    logic               in_ready;
    logic               w_on;
    logic               accept;
    logic               push;
    logic               pop;
    logic [CNT_W-1:0]   remain;
    logic [NREG-1:0]    pend_mask;

    // Handshake decode; flush cancels both sides of the edge.
    always_comb begin
        in_ready = (count_q != CNT_W'(DEPTH));
        w_on     = (count_q != '0);
        accept   = bus.in_valid && in_ready;
        push     = accept && bus.in_wen && !(R0_ZERO && (bus.in_addr == '0)) && !bus.flush;
        pop      = w_on && bus.rf_ready && !bus.flush;
        remain   = count_q - CNT_W'(pop);
    end

    // Next pointers and occupancy.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (bus.flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) tail_d = tail_q + PTR_W'(1);
            if (pop)  head_d = head_q + PTR_W'(1);
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (!push && pop) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    // Head output registers track whichever entry is at the head after the edge.
    always_comb begin
        waddr_d    = waddr_q;
        data_out_d = data_out_q;
        if (!bus.flush) begin
            if (remain != '0) begin
                waddr_d    = mem_addr_q[head_d];
                data_out_d = mem_data_q[head_d];
            end else if (push) begin
                // Queue empty after the pop: the incoming entry becomes the head.
                waddr_d    = bus.in_addr;
                data_out_d = bus.in_data;
            end
        end
    end

    // Commit notification, one cycle after the register file takes the write.
    always_comb begin
        endwrite_d = pop;
        endreg_d   = pop ? waddr_q : endreg_q;
    end

    // Pending-register mask over the valid window [head, head+count).
    always_comb begin
        pend_mask = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (CNT_W'(k) < count_q) begin
                pend_mask[mem_addr_q[head_q + PTR_W'(k)]] = 1'b1;
            end
        end
    end

    // Control and output state with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            waddr_q    <= '0;
            data_out_q <= '0;
            endwrite_q <= 1'b0;
            endreg_q   <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            waddr_q    <= waddr_d;
            data_out_q <= data_out_d;
            endwrite_q <= endwrite_d;
            endreg_q   <= endreg_d;
        end
    end

    // Entry storage write at the tail.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr_q[tail_q] <= bus.in_addr;
            mem_data_q[tail_q] <= bus.in_data;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.w_on      = w_on;
    assign bus.waddr     = waddr_q;
    assign bus.data_out  = data_out_q;
    assign bus.endwrite  = endwrite_q;
    assign bus.endreg    = endreg_q;
    assign bus.pend_mask = pend_mask;
    assign bus.count     = count_q;
endmodule

// File: doc/writeback_queue.md
WRITEBACK_QUEUE -- requirements
Module: writeback_queue

Interface
REQ-001 Parameter DATA_W, default 16: register data width in bits.
REQ-002 Parameter RADDR_W, default 4: register address width; the register file has 2**RADDR_W entries.
REQ-003 Parameter DEPTH, default 4: queue entries; power of two, minimum 2.
REQ-004 Parameter R0_ZERO, default 1: when 1, writes addressed to register 0 are dropped.
REQ-005 CLK  input  1  single clock; all state updates on its rising edge.
REQ-006 RST_N  input  1  reset, asynchronous, active-low.
REQ-007 IN_VALID  input  1  upstream write request valid.
REQ-008 IN_READY  output  1  queue can accept a request this cycle.
REQ-009 IN_WEN  input  1  request writes the register file (decoded upstream: ADD, SUB, OR, AND, SLT, ADDI, LW).
REQ-010 IN_ADDR  input  RADDR_W  destination register.
REQ-011 IN_DATA  input  DATA_W  write data.
REQ-012 FLUSH  input  1  synchronous discard of all queued writes.
REQ-013 W_ON  output  1  register-file write valid (head entry present).
REQ-014 WADDR  output  RADDR_W  head destination register.
REQ-015 DATA_OUT  output  DATA_W  head write data.
REQ-016 RF_READY  input  1  register file accepts the write this cycle.
REQ-017 ENDWRITE  output  1  one-cycle pulse: a write committed on the previous edge.
REQ-018 ENDREG  output  RADDR_W  register committed, valid while ENDWRITE=1.
REQ-019 PEND_MASK  output  2**RADDR_W  bit r=1 while any queued entry targets register r.
REQ-020 COUNT  output  clog2(DEPTH+1)  number of queued entries.

Function
REQ-021 Accept occurs on a rising edge with IN_VALID=1 and IN_READY=1.
REQ-022 IN_READY shall be 1 when COUNT<DEPTH, otherwise 0; there is no pass-through when the queue is full, even if a commit happens in the same cycle.
REQ-023 An accepted request with IN_WEN=0, or with R0_ZERO=1 and IN_ADDR=0, is consumed and not queued.
REQ-024 Any other accepted request is written at the tail; it becomes visible on W_ON no earlier than the following cycle (minimum latency 1 cycle, accept to W_ON).
REQ-025 W_ON, WADDR and DATA_OUT shall be driven from the head entry; W_ON=(COUNT!=0); WADDR and DATA_OUT hold their last value when COUNT=0.
REQ-026 Commit occurs on a rising edge with W_ON=1 and RF_READY=1; the head pops and the queue preserves strict FIFO order.
REQ-027 On the edge after a commit, ENDWRITE=1 and ENDREG=committed address; otherwise ENDWRITE=0 and ENDREG holds its value.
REQ-028 A simultaneous accept and commit with 0<COUNT<DEPTH leaves COUNT unchanged.
REQ-029 When COUNT=0, a simultaneous accept and commit is impossible because W_ON=0.
REQ-030 Head/tail pointers are log2(DEPTH) bits and wrap modulo DEPTH; COUNT distinguishes full from empty.
REQ-031 PEND_MASK is combinational: the OR of the one-hot addresses of all valid entries; duplicate addresses are allowed.
REQ-032 FLUSH=1 at an edge empties the queue, ignores any accept and any commit at that edge, and leaves ENDWRITE=0 on the next cycle.
REQ-033 IN_READY is not gated by FLUSH.
REQ-034 Internal data storage need not be reset; only pointers, COUNT and the output registers are.

Reset
REQ-035 While RST_N=0: COUNT=0, W_ON=0, WADDR=0, DATA_OUT=0, ENDWRITE=0, ENDREG=0, PEND_MASK=0, IN_READY=1.
REQ-036 Reset asserted mid-operation discards all queued entries immediately, without waiting for a clock edge.
REQ-037 After RST_N is released, the first accept may occur on the first rising edge.

Verification
REQ-038 Single write: RF_READY=1, accept ADD r3=0x1234 -> next cycle W_ON=1, WADDR=3, DATA_OUT=0x1234; one cycle later ENDWRITE=1, ENDREG=3, COUNT=0.
REQ-039 Fill/backpressure: RF_READY=0, accept 4 writes (r1..r4) -> IN_READY=0, COUNT=4, PEND_MASK=0x001E; raise RF_READY -> commits in order r1,r2,r3,r4 on 4 consecutive edges.
REQ-040 Drops: accept SW (IN_WEN=0) and ADDI to r0 with R0_ZERO=1 -> COUNT stays 0, W_ON never asserts, ENDWRITE never pulses.
REQ-041 Concurrent push/pop at COUNT=2 with duplicate address r5 twice -> COUNT stays 2, PEND_MASK bit5 stays 1 until the last r5 entry commits.
REQ-042 FLUSH with COUNT=3 and RF_READY=1 -> COUNT=0, W_ON=0, no ENDWRITE pulse on the next cycle.
REQ-043 RST_N pulsed low between clock edges with COUNT=3 -> all outputs at reset values immediately; a write accepted after release commits normally.
